// File: rtl/uart_tx_fifo_feeder.sv
// Circular byte FIFO feeding a UART transmitter, releasing one byte per fixed
// pacing interval so the transmitter itself needs no busy handshake.
module uart_tx_fifo_feeder #(
    parameter int DATA_BITS      = 8,
    parameter int DEPTH          = 16,
    parameter int COUNTS_PER_BIT = 434,
    parameter int FRAME_BITS     = 11,
    parameter int IDLE_BITS      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DATA_BITS-1:0]   tx_data,
    output logic                   tx_send,
    output logic                   busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PACE   = COUNTS_PER_BIT * (FRAME_BITS + IDLE_BITS);
    localparam int PACE_W = $clog2(PACE + 1);
    // Counting PACE-1 down to 0 gives exactly PACE cycles in WAIT.
    localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(PACE - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t               state, state_next;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PACE_W-1:0]    pace_cnt;
    logic [CNT_W-1:0]     count_next;
    logic                 push, pop;

    assign push       = wr_en && !full;
    assign pop        = (state == LOAD);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign busy       = (state != IDLE);

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every output of this block gets a default first, otherwise any
    // unassigned path would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (count != '0) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: state_next = WAIT;
            WAIT: if (pace_cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the storage array has no reset; contents are only ever read after
    // being written, and leaving it out keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_data  <= '0;
            tx_send  <= 1'b0;
            pace_cnt <= '0;
        end else begin
            count    <= count_next;
            full     <= (count_next == CNT_W'(DEPTH));
            empty    <= (count_next == '0);
            // Dropped byte is flagged even when a pop frees space this cycle.
            overflow <= wr_en && full;
            tx_send  <= pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (state == SEND)
                pace_cnt <= PACE_LAST;
            else if (state == WAIT && pace_cnt != '0)
                pace_cnt <= pace_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder with DEPTH=4, COUNTS_PER_BIT=4 (PACE=48);
// cycle numbers below are relative to the cycle in which the first byte is written.
module tb_uart_tx_fifo_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx_send, busy;
    logic [2:0] count;
    logic [7:0] tx_data;

    uart_tx_fifo_feeder #(
        .DATA_BITS(8), .DEPTH(4), .COUNTS_PER_BIT(4), .FRAME_BITS(11), .IDLE_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .tx_data(tx_data), .tx_send(tx_send), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    int vectors = 0;
    int miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame log: every tx_send pulse with its relative cycle and byte.
    logic [7:0] pdata[$];
    int         pcyc[$];
    logic [7:0] ed[$];
    int         ec[$];
    int         ovf_n = 0;
    int         dbl_n = 0;
    logic       prev_send = 1'b0;

    always @(negedge clk) begin
        if (rst && tx_send) begin
            pdata.push_back(tx_data);
            pcyc.push_back(cyc - t0);
        end
        if (overflow) ovf_n++;
        if (tx_send && prev_send) dbl_n++;
        prev_send = tx_send;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        @(negedge clk);
        pdata.delete();
        pcyc.delete();
        ed.delete();
        ec.delete();
        ovf_n = 0;
        t0 = cyc;
    endtask

    task automatic wait_to(input int n);
        while (cyc - t0 < n) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] d, input int c);
        ed.push_back(d);
        ec.push_back(c);
    endtask

    task automatic check_frames(input string tag);
        chk({tag, " frame count"}, pdata.size(), ed.size());
        for (int i = 0; i < pdata.size() && i < ed.size(); i++) begin
            chk($sformatf("%s frame%0d data", tag, i), pdata[i], ed[i]);
            chk($sformatf("%s frame%0d cycle", tag, i), pcyc[i], ec[i]);
        end
    endtask

    initial begin
        // 1: reset, then idle
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start();
        wait_to(20);
        chk("t1 tx_send", tx_send, 1'b0);
        chk("t1 busy", busy, 1'b0);
        chk("t1 empty", empty, 1'b1);
        chk("t1 full", full, 1'b0);
        chk("t1 count", count, 3'd0);
        chk("t1 tx_data", tx_data, 8'h00);
        chk("t1 overflow", overflow, 1'b0);

        // 2: single byte, latency and pacing
        start();
        write(8'hA5);
        chk("t2 count c1", count, 3'd1);
        chk("t2 busy c1", busy, 1'b0);
        wait_to(2);
        chk("t2 busy c2", busy, 1'b1);
        chk("t2 tx_send c2", tx_send, 1'b0);
        wait_to(3);
        chk("t2 tx_send c3", tx_send, 1'b1);
        chk("t2 tx_data c3", tx_data, 8'hA5);
        chk("t2 empty c3", empty, 1'b1);
        wait_to(51);
        chk("t2 busy c51", busy, 1'b1);
        chk("t2 tx_data c51", tx_data, 8'hA5);
        wait_to(52);
        chk("t2 busy c52", busy, 1'b0);
        wait_to(60);
        expect_frame(8'hA5, 3);
        check_frames("t2");

        // 3: three bytes, PACE+3 spacing
        start();
        write(8'h11);
        write(8'h22);
        write(8'h33);
        chk("t3 count c3", count, 3'd2);
        wait_to(160);
        expect_frame(8'h11, 3);
        expect_frame(8'h22, 54);
        expect_frame(8'h33, 105);
        check_frames("t3");
        chk("t3 busy end", busy, 1'b0);

        // 4: six writes, the sixth overflows
        start();
        for (int i = 1; i <= 5; i++) write(8'(i));
        chk("t4 full c5", full, 1'b1);
        chk("t4 count c5", count, 3'd4);
        write(8'h06);
        chk("t4 overflow c6", overflow, 1'b1);
        chk("t4 count c6", count, 3'd4);
        @(negedge clk);
        chk("t4 overflow c7", overflow, 1'b0);
        wait_to(270);
        for (int i = 0; i < 5; i++) expect_frame(8'(i + 1), 3 + 51 * i);
        check_frames("t4");
        chk("t4 overflow pulses", ovf_n, 1);
        chk("t4 empty end", empty, 1'b1);

        // 5: refill as LOAD pops, pointer wrap, drop while full with pop
        start();
        write(8'hA0);
        write(8'hA1);
        write(8'hA2);
        chk("t5 push+pop count c3", count, 3'd2);
        write(8'hA3);
        chk("t5 count c4", count, 3'd3);
        wait_to(10);
        write(8'hA4);
        chk("t5 full c11", full, 1'b1);
        chk("t5 count c11", count, 3'd4);
        wait_to(54);
        chk("t5 count c54", count, 3'd3);
        write(8'hA5);
        chk("t5 count c55", count, 3'd4);
        chk("t5 overflow c55", overflow, 1'b0);
        wait_to(104);
        write(8'hEE);
        chk("t5 overflow c105", overflow, 1'b1);
        chk("t5 count c105", count, 3'd3);
        wait_to(320);
        for (int i = 0; i < 6; i++) expect_frame(8'hA0 + 8'(i), 3 + 51 * i);
        check_frames("t5");
        chk("t5 overflow pulses", ovf_n, 1);

        // 6: reset during WAIT with two bytes queued
        start();
        write(8'hB1);
        write(8'hB2);
        write(8'hB3);
        chk("t6 count c3", count, 3'd2);
        wait_to(10);
        chk("t6 busy before rst", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6 empty in rst", empty, 1'b1);
        chk("t6 busy in rst", busy, 1'b0);
        chk("t6 tx_send in rst", tx_send, 1'b0);
        chk("t6 count in rst", count, 3'd0);
        pdata.delete();
        pcyc.delete();
        wr_en   = 1'b1;
        wr_data = 8'hFF;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        repeat (150) @(negedge clk);
        chk("t6 pulses after rst", pdata.size(), 0);
        chk("t6 empty after rst", empty, 1'b1);
        chk("t6 count after rst", count, 3'd0);
        start();
        write(8'hC7);
        wait_to(10);
        expect_frame(8'hC7, 3);
        check_frames("t6");

        chk("tx_send never back-to-back", dbl_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
